key_led_ctrl: RTL and testbench

Parametrised multi-channel key-to-LED controller: each of CH push-button inputs is synchronised, debounced, and drives one LED output. The LED either follows the debounced key level or toggles on each accepted press, selected per channel at run time. A one-cycle press flag per channel is exported for downstream logic. It sits between the board push-buttons and the LED pins, replacing direct registered key-to-LED paths.

---
 rtl/key_led_ctrl.sv | 94 +++++++++
 tb/tb_key_led_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: per-channel key synchroniser, debouncer and LED driver.
// Each channel runs the same lane logic; the top is an array of lanes.

module key_led_lane #(
  parameter int CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_key,
  input  logic i_mode,
  output logic o_led,
  output logic o_flag
);
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  logic          r_s1, r_s2;
  logic          r_stb, r_stb_d;
  logic [CW-1:0] r_cnt;
  logic          r_led, r_flag;
  logic          w_press;

  // press = accepted level just fell from released (1) to pressed (0)
  assign w_press = r_stb_d & ~r_stb;

  // two-flop synchroniser; idles at released (1)
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
    end
  end

  // debounce: accept s2 only after CNT_MAX+1 consecutive cycles differing from stb
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stb <= 1'b1;
      r_cnt <= '0;
    end else if (r_s2 == r_stb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_TOP) begin
      r_stb <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // delayed copy of stb for edge detection, and registered press flag
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stb_d <= 1'b1;
      r_flag  <= 1'b0;
    end else begin
      r_stb_d <= r_stb;
      r_flag  <= w_press;
    end
  end

  // LED: follow the inverted accepted level, or toggle on each press
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)     r_led <= 1'b0;
    else if (i_mode) r_led <= r_led ^ w_press;
    else             r_led <= ~r_stb;
  end

  assign o_led  = r_led;
  assign o_flag = r_flag;
endmodule

module key_led_ctrl #(
  parameter int CH      = 4,
  parameter int CNT_MAX = 999_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [CH-1:0] key_in,
  input  logic [CH-1:0] mode,
  output logic [CH-1:0] led_out,
  output logic [CH-1:0] key_flag
);
  // one independent lane per channel, no cross-channel interaction
  key_led_lane #(.CNT_MAX(CNT_MAX)) u_lane [CH-1:0] (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_key   (key_in),
    .i_mode  (mode),
    .o_led   (led_out),
    .o_flag  (key_flag)
  );
endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl: window-based behavioural model compared every cycle,
// plus hand-computed literal checks at the key points of each scenario.

module tb_key_led_ctrl;
  localparam int CH      = 2;
  localparam int CNT_MAX = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [CH-1:0] key_in;
  logic [CH-1:0] mode;
  logic [CH-1:0] led_out;
  logic [CH-1:0] key_flag;

  int n_cmp = 0;
  int n_err = 0;

  key_led_ctrl #(.CH(CH), .CNT_MAX(CNT_MAX)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key_in   (key_in),
    .mode     (mode),
    .led_out  (led_out),
    .key_flag (key_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Model: history of raw key samples; a level is accepted when every one of the
  // CNT_MAX+1 synchronised samples (two edges old or older) disagrees with it.
  logic [CH-1:0] m_stb, m_stbp, m_led, m_flag;
  logic [15:0]   m_hist [CH];

  always @(posedge sys_clk or posedge sys_rst) begin
    bit acc, press;
    if (sys_rst) begin
      m_stb = '1; m_stbp = '1; m_led = '0; m_flag = '0;
      for (int c = 0; c < CH; c++) m_hist[c] = '1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        press = m_stbp[c] & ~m_stb[c];
        acc = 1'b1;
        for (int k = 1; k <= CNT_MAX + 1; k++)
          if (m_hist[c][k] == m_stb[c]) acc = 1'b0;
        m_flag[c] = press;
        m_led[c]  = mode[c] ? (m_led[c] ^ press) : ~m_stb[c];
        m_stbp[c] = m_stb[c];
        if (acc) m_stb[c] = ~m_stb[c];
        m_hist[c] = {m_hist[c][14:0], key_in[c]};
      end
    end
  end

  // every-cycle comparison against the model, away from the edge
  always @(posedge sys_clk) begin
    #1;
    chk("model_led", led_out, m_led);
    chk("model_flag", key_flag, m_flag);
  end

  // wait n rising edges, then settle just past the last one
  task automatic edges(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_key(input logic [CH-1:0] k);
    @(negedge sys_clk);
    key_in = k;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1; key_in = 2'b11; mode = 2'b00;
    #2;
    chk("reset_led", led_out, 2'b00);
    chk("reset_flag", key_flag, 2'b00);
    edges(3);
    @(negedge sys_clk); sys_rst = 1'b0;
    edges(3);

    // clean press on ch0, follow mode
    drive_key(2'b10);
    edges(6);
    chk("press_flag_e6", key_flag, 2'b00);
    chk("press_led_e6", led_out, 2'b00);
    edges(1);
    chk("press_flag_e7", key_flag, 2'b01);
    chk("press_led_e7", led_out, 2'b01);
    edges(1);
    chk("press_flag_e8", key_flag, 2'b00);
    chk("press_led_e8", led_out, 2'b01);
    drive_key(2'b11);
    edges(6);
    chk("release_led_e6", led_out, 2'b01);
    edges(1);
    chk("release_led_e7", led_out, 2'b00);
    chk("release_flag_e7", key_flag, 2'b00);
    edges(3);

    // bounce: low 3 cycles, high 1 cycle, repeated
    for (int r = 0; r < 5; r++) begin
      drive_key(2'b10);
      edges(0);
      for (int j = 0; j < 2; j++) begin
        @(negedge sys_clk);
        chk("bounce_led", led_out, 2'b00);
        chk("bounce_flag", key_flag, 2'b00);
      end
      drive_key(2'b11);
    end
    edges(8);
    chk("bounce_end_led", led_out, 2'b00);

    // toggle mode on ch0: led 1, 0, 1
    mode = 2'b01;
    for (int t = 0; t < 3; t++) begin
      drive_key(2'b10);
      edges(7);
      chk("toggle_flag", key_flag, 2'b01);
      chk("toggle_led", led_out[0] ? 2'b01 : 2'b00, (t % 2 == 0) ? 2'b01 : 2'b00);
      drive_key(2'b11);
      edges(9);
      chk("toggle_hold", key_flag, 2'b00);
    end
    // ch1 follows its level while ch0 stays toggled on
    drive_key(2'b01);
    edges(7);
    chk("ch1_follow_on", led_out, 2'b11);
    chk("ch1_flag", key_flag, 2'b10);
    drive_key(2'b11);
    edges(7);
    chk("ch1_follow_off", led_out, 2'b01);
    edges(2);

    // simultaneous press: ch0 toggles 1->0, ch1 lights
    drive_key(2'b00);
    edges(7);
    chk("simul_flag", key_flag, 2'b11);
    chk("simul_led", led_out, 2'b10);
    @(negedge sys_clk); mode = 2'b00;
    edges(1);
    chk("mode_switch_led", led_out, 2'b11);
    edges(2);

    // asynchronous reset mid-cycle while LEDs lit
    #3 sys_rst = 1'b1;
    #1;
    chk("async_rst_led", led_out, 2'b00);
    chk("async_rst_flag", key_flag, 2'b00);
    // keys held through reset: fresh press 7 edges after release
    @(negedge sys_clk); sys_rst = 1'b0;
    edges(6);
    chk("held_rst_flag_e6", key_flag, 2'b00);
    edges(1);
    chk("held_rst_flag_e7", key_flag, 2'b11);
    chk("held_rst_led_e7", led_out, 2'b11);
    drive_key(2'b11);
    edges(10);

    // reset in the middle of a ch0 debounce
    drive_key(2'b10);
    edges(4);
    sys_rst = 1'b1;
    @(negedge sys_clk); sys_rst = 1'b0;
    edges(6);
    chk("mid_rst_flag_e6", key_flag, 2'b00);
    edges(1);
    chk("mid_rst_flag_e7", key_flag, 2'b01);
    chk("mid_rst_led_e7", led_out, 2'b01);
    drive_key(2'b11);
    edges(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
